// File: rtl/simple_cpu_pkg.sv
// Shared definitions for the CPU instruction-memory stage and its boot loader.
package simple_cpu_pkg;

    localparam int IM_ADDR_W = 8;
    localparam int IM_DATA_W = 16;

    typedef enum logic [2:0] {
        LEN  = 3'd0,
        HI   = 3'd1,
        LO   = 3'd2,
        CHK  = 3'd3,
        HOLD = 3'd4,
        RUN  = 3'd5,
        ERR  = 3'd6
    } ld_state_e;

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous instruction RAM; rdata updates only when re is high.
module imem_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction RAM with a byte-stream boot loader; holds the CPU in reset until
// a program image with a matching XOR checksum has been written.
module imem_loader
    import simple_cpu_pkg::*;
#(
    parameter int ADDR_W   = IM_ADDR_W,
    parameter int DATA_W   = IM_DATA_W,
    parameter int HOLD_CYC = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    input  logic              ld_start,
    output logic              cpu_reset,
    output logic              load_err,
    input  logic              im_abus_valid,
    input  logic [ADDR_W-1:0] im_abus_data,
    output logic [DATA_W-1:0] im_dbus
);

    localparam int HW = $clog2(HOLD_CYC + 1) + 1;

    ld_state_e         state, state_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx, addr_inc;
    logic [ADDR_W-1:0] len_q, len_nx;
    logic [7:0]        hi_q, hi_nx;
    logic [7:0]        csum_q, csum_nx;
    logic [HW-1:0]     hold_q, hold_nx;
    logic              err_nx;
    logic              xfer;
    logic              we;
    logic              re;
    logic              zero_q;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    assign ld_ready  = (state == LEN) || (state == HI) || (state == LO) || (state == CHK);
    assign cpu_reset = (state != RUN);
    assign xfer      = ld_valid && ld_ready;
    assign addr_inc  = addr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LEN;
            addr_q   <= '0;
            len_q    <= '0;
            hi_q     <= '0;
            csum_q   <= '0;
            hold_q   <= '0;
            load_err <= 1'b0;
        end else begin
            state    <= state_nx;
            addr_q   <= addr_nx;
            len_q    <= len_nx;
            hi_q     <= hi_nx;
            csum_q   <= csum_nx;
            hold_q   <= hold_nx;
            load_err <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = addr_q;
        len_nx   = len_q;
        hi_nx    = hi_q;
        csum_nx  = csum_q;
        hold_nx  = hold_q;
        err_nx   = load_err;
        we       = 1'b0;
        unique case (state)
            LEN: if (xfer) begin
                // N=0 means a full 2**ADDR_W image: the wrapped increment matches 0
                len_nx   = ADDR_W'(ld_data);
                addr_nx  = '0;
                csum_nx  = '0;
                state_nx = HI;
            end
            HI: if (xfer) begin
                hi_nx    = ld_data;
                csum_nx  = csum_q ^ ld_data;
                state_nx = LO;
            end
            LO: if (xfer) begin
                csum_nx  = csum_q ^ ld_data;
                we       = 1'b1;
                addr_nx  = addr_inc;
                state_nx = (addr_inc == len_q) ? CHK : HI;
            end
            CHK: if (xfer) begin
                if (ld_data == csum_q) begin
                    hold_nx  = HW'(HOLD_CYC);
                    state_nx = HOLD;
                end else begin
                    err_nx   = 1'b1;
                    state_nx = ERR;
                end
            end
            HOLD: begin
                if (hold_q == '0)
                    state_nx = RUN;
                else
                    hold_nx = hold_q - 1'b1;
            end
            RUN, ERR: if (ld_start) begin
                err_nx   = 1'b0;
                state_nx = LEN;
            end
            default: state_nx = LEN;
        endcase
    end

    // Fetch port owns the RAM only in RUN; loads never overlap with reads.
    assign ram_addr = (state == RUN) ? im_abus_data : addr_q;
    assign re       = (state == RUN) && im_abus_valid;

    imem_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .re    (re),
        .addr  (ram_addr),
        .wdata (DATA_W'({hi_q, ld_data})),
        .rdata (ram_rdata)
    );

    // rdata holds between fetches; this flag forces zero outside RUN until a
    // fresh fetch lands, so the RAM itself needs no reset.
    always_ff @(posedge clk) begin
        if (reset)
            zero_q <= 1'b1;
        else if (state != RUN)
            zero_q <= 1'b1;
        else if (im_abus_valid)
            zero_q <= 1'b0;
    end

    assign im_dbus = zero_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad/throttled/full loads, reset abort, fetch gating.
module tb_imem_loader;
    import simple_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        ld_start;
    logic        cpu_reset;
    logic        load_err;
    logic        im_abus_valid;
    logic [7:0]  im_abus_data;
    logic [15:0] im_dbus;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(8), .DATA_W(16), .HOLD_CYC(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .ld_valid      (ld_valid),
        .ld_data       (ld_data),
        .ld_ready      (ld_ready),
        .ld_start      (ld_start),
        .cpu_reset     (cpu_reset),
        .load_err      (load_err),
        .im_abus_valid (im_abus_valid),
        .im_abus_data  (im_abus_data),
        .im_dbus       (im_dbus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        ld_valid = 1'b1;
        ld_data  = b;
        while (!ld_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ld_ready) begin
            chk("ready_timeout", 32'd0, 32'd1);
            ld_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        ld_valid = 1'b0;
        ld_data  = 8'h5A;
    endtask

    task automatic send_small(input logic [7:0] cs, input int gap);
        logic [7:0] img [6];
        img = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00};
        img[5] = cs;
        for (int k = 0; k < 6; k++) begin
            send_byte(img[k]);
            if (k < 5 && gap > 0) begin
                repeat (gap) @(negedge clk);
                if (k == 0) chk("thr_state", 32'(dut.state), 32'(HI));
            end
        end
    endtask

    task automatic send_full(input bit inv);
        logic [7:0]  b;
        logic [15:0] w;
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            w = inv ? {~b, b} : {b, ~b};
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
        send_byte(8'h00);
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (cpu_reset && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(cpu_reset), 32'd0);
    endtask

    task automatic fetch(input string tag, input logic [7:0] a, input logic [15:0] exp);
        im_abus_valid = 1'b1;
        im_abus_data  = a;
        @(negedge clk);
        im_abus_valid = 1'b0;
        chk(tag, 32'(im_dbus), 32'(exp));
    endtask

    task automatic pulse_start();
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
    endtask

    task automatic readback_full(input string tag, input bit inv);
        logic [7:0] b;
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            fetch(tag, b, inv ? {~b, b} : {b, ~b});
        end
    endtask

    initial begin
        reset = 1'b1;
        ld_valid = 1'b0;
        ld_data = 8'h00;
        ld_start = 1'b0;
        im_abus_valid = 1'b0;
        im_abus_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 32'(dut.state), 32'(LEN));
        chk("rst_ready", 32'(ld_ready), 32'd1);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_dbus", 32'(im_dbus), 32'd0);
        reset = 1'b0;

        // Good image: XOR of 12,34,AB,CD is 40
        send_small(8'h40, 0);
        chk("good_err", 32'(load_err), 32'd0);
        im_abus_valid = 1'b1;
        im_abus_data  = 8'h01;
        repeat (4) @(negedge clk);
        chk("hold_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("hold_dbus", 32'(im_dbus), 32'd0);
        chk("hold_ready", 32'(ld_ready), 32'd0);
        @(negedge clk);
        chk("run_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("run_dbus_first", 32'(im_dbus), 32'd0);
        im_abus_valid = 1'b0;
        fetch("good_ram0", 8'h00, 16'h1234);
        fetch("good_ram1", 8'h01, 16'hABCD);

        // Fetch gating: valid 1,0,1 with addresses 00,01,01
        im_abus_valid = 1'b1; im_abus_data = 8'h00;
        @(negedge clk);
        chk("tog_v1", 32'(im_dbus), 32'h1234);
        im_abus_valid = 1'b0; im_abus_data = 8'h01;
        @(negedge clk);
        chk("tog_hold", 32'(im_dbus), 32'h1234);
        im_abus_valid = 1'b1; im_abus_data = 8'h01;
        @(negedge clk);
        chk("tog_v2", 32'(im_dbus), 32'hABCD);
        im_abus_valid = 1'b0;

        // Bad checksum
        pulse_start();
        chk("restart_ready", 32'(ld_ready), 32'd1);
        chk("restart_cpu_reset", 32'(cpu_reset), 32'd1);
        send_small(8'h00, 0);
        chk("bad_err", 32'(load_err), 32'd1);
        chk("bad_ready", 32'(ld_ready), 32'd0);
        ld_valid = 1'b1; ld_data = 8'h40;
        repeat (3) @(negedge clk);
        ld_valid = 1'b0;
        chk("bad_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("bad_state", 32'(dut.state), 32'(ERR));
        pulse_start();
        chk("clr_err", 32'(load_err), 32'd0);
        chk("clr_ready", 32'(ld_ready), 32'd1);

        // Throttled source, 3 idle cycles between bytes
        send_small(8'h40, 3);
        wait_run("thr_run");
        chk("thr_err", 32'(load_err), 32'd0);
        fetch("thr_ram0", 8'h00, 16'h1234);
        fetch("thr_ram1", 8'h01, 16'hABCD);

        // Full 256-word image, word i = {i, ~i}; checksum is 00
        pulse_start();
        send_full(1'b0);
        wait_run("full_run");
        chk("full_err", 32'(load_err), 32'd0);
        readback_full("full_rd", 1'b0);

        // Reset after the 3rd byte aborts the load
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        im_abus_valid = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        im_abus_valid = 1'b0;
        chk("abort_state", 32'(dut.state), 32'(LEN));
        chk("abort_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("abort_dbus", 32'(im_dbus), 32'd0);
        chk("abort_csum", 32'(dut.csum_q), 32'd0);
        send_full(1'b1);
        wait_run("refill_run");
        chk("refill_err", 32'(load_err), 32'd0);
        readback_full("refill_rd", 1'b1);

        // Reset and ld_start together from RUN: reset takes it to LEN
        ld_start = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        reset = 1'b0;
        chk("rst_start_state", 32'(dut.state), 32'(LEN));
        chk("rst_start_err", 32'(load_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
